// File: rtl/fetch_pkg.sv
// Shared state, redirect-source encoding and parameter defaults for the fetch sequencer.
package fetch_pkg;

   localparam int unsigned     XLEN_DEFAULT     = 32;
   localparam longint unsigned RESET_PC_DEFAULT = 0;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

   typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_MRET, SRC_TRAP} redir_src_t;

   // Fixed priority: trap > mret > branch.
   function automatic redir_src_t pick_src(input logic trap, input logic mret, input logic branch);
      if (trap)        return SRC_TRAP;
      else if (mret)   return SRC_MRET;
      else if (branch) return SRC_BRANCH;
      else             return SRC_NONE;
   endfunction

endpackage

// File: rtl/redirect_arb.sv
// Combinational priority mux selecting the winning redirect source and its target.
module redirect_arb
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_req,
   input  logic [XLEN-1:0] mret_pc,
   input  logic            branch_req,
   input  logic [XLEN-1:0] branch_pc,
   output logic            redir,
   output logic [XLEN-1:0] redir_pc
);

   redir_src_t src;

   always_comb begin
      src      = pick_src(trap_req, mret_req, branch_req);
      redir    = (src != SRC_NONE);
      redir_pc = '0;
      case (src)
         SRC_TRAP:   redir_pc = trap_pc;
         SRC_MRET:   redir_pc = mret_pc;
         SRC_BRANCH: redir_pc = branch_pc;
         default:    redir_pc = '0;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, single-outstanding ibus, redirect handling.
// Define FETCH_MISALIGN_EXC_EN to report misaligned redirect targets instead of aligning them.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_req,
   input  logic [XLEN-1:0] mret_pc,
   input  logic            branch_req,
   input  logic [XLEN-1:0] branch_pc,
   output logic            ibus_req,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_ready,
   input  logic            ibus_rvalid,
   input  logic [XLEN-1:0] ibus_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            if_misalign,
   input  logic            if_ready
);

`ifdef FETCH_MISALIGN_EXC_EN
   localparam bit              MISALIGN_EN = 1'b1;
   localparam logic [XLEN-1:0] TGT_MASK    = '1;
`else
   localparam bit              MISALIGN_EN = 1'b0;
   localparam logic [XLEN-1:0] TGT_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
`endif

   fetch_state_t    state;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pend_pc;
   logic [XLEN-1:0] arb_pc;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] tgt;
   logic            redir;
   logic            kill;
   logic            pend_vld;
   logic            launch;
   logic            tgt_misaligned;
   logic            misalign_q;

   redirect_arb #(.XLEN(XLEN)) u_arb (
      .trap_req   (trap_req),
      .trap_pc    (trap_pc),
      .mret_req   (mret_req),
      .mret_pc    (mret_pc),
      .branch_req (branch_req),
      .branch_pc  (branch_pc),
      .redir      (redir),
      .redir_pc   (arb_pc)
   );

   assign redir_pc    = arb_pc & TGT_MASK;
   assign ibus_req    = (state == REQ);
   assign ibus_addr   = pc_reg;
   assign if_misalign = misalign_q;

   // Every path that starts a fresh fetch (from IDLE, a discarded response, or HOLD)
   // funnels through one launch target so the misalignment check lives in one place.
   always_comb begin
      launch = 1'b0;
      tgt    = pc_reg;
      unique case (state)
         IDLE: begin
            launch = 1'b1;
            tgt    = redir ? redir_pc : pc_reg;
         end
         WAIT: begin
            if (ibus_rvalid && (kill || pend_vld || redir)) begin
               launch = 1'b1;
               tgt    = redir ? redir_pc : pend_pc;
            end
         end
         HOLD: begin
            if (redir) begin
               launch = 1'b1;
               tgt    = redir_pc;
            end else if (if_ready) begin
               launch = 1'b1;
               tgt    = pc_reg + XLEN'(4);
            end
         end
         default: ;
      endcase
      tgt_misaligned = MISALIGN_EN && (tgt[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc_reg     <= RESET_PC;
         pend_pc    <= '0;
         kill       <= 1'b0;
         pend_vld   <= 1'b0;
         if_valid   <= 1'b0;
         if_pc      <= '0;
         if_instr   <= '0;
         misalign_q <= 1'b0;
      end else if (launch) begin
         pc_reg   <= tgt;
         kill     <= 1'b0;
         pend_vld <= 1'b0;
         if (tgt_misaligned) begin
            state      <= HOLD;
            if_valid   <= 1'b1;
            if_pc      <= tgt;
            if_instr   <= '0;
            misalign_q <= 1'b1;
         end else begin
            state      <= REQ;
            if_valid   <= 1'b0;
            misalign_q <= 1'b0;
         end
      end else begin
         unique case (state)
            REQ: begin
               // pc_reg stays put so the address on the bus is not disturbed.
               if (redir) begin
                  pend_pc  <= redir_pc;
                  pend_vld <= 1'b1;
                  kill     <= 1'b1;
               end
               if (ibus_ready) state <= WAIT;
            end
            WAIT: begin
               if (ibus_rvalid) begin
                  if_pc      <= pc_reg;
                  if_instr   <= ibus_rdata;
                  if_valid   <= 1'b1;
                  misalign_q <= 1'b0;
                  state      <= HOLD;
               end else if (redir) begin
                  pend_pc  <= redir_pc;
                  pend_vld <= 1'b1;
                  kill     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_ctrl;

`ifdef FETCH_MISALIGN_EXC_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trap_req = 1'b0, mret_req = 1'b0, branch_req = 1'b0;
   logic [31:0] trap_pc = '0, mret_pc = '0, branch_pc = '0;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ready = 1'b0, ibus_rvalid = 1'b0;
   logic [31:0] ibus_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;
   logic        if_misalign;
   logic        if_ready = 1'b0;

   always #5 clk = ~clk;

   fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_pc(trap_pc),
      .mret_req(mret_req), .mret_pc(mret_pc),
      .branch_req(branch_req), .branch_pc(branch_pc),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .if_misalign(if_misalign), .if_ready(if_ready)
   );

   int n_chk = 0, n_fail = 0;

   // stimulus control
   bit          rnd_mode = 1'b0, fixed_instr = 1'b1, rst_next = 1'b1;
   logic        d_trap = 0, d_mret = 0, d_branch = 0, d_ready = 0, d_if_ready = 0;
   logic [31:0] d_trap_pc = '0, d_mret_pc = '0, d_branch_pc = '0;

   // memory responder
   bit          mem_busy = 1'b0, late_rv = 1'b0;
   int          mem_cnt = 0, mem_lat = 1;
   logic [31:0] mem_addr = '0;

   // per-cycle samples and logs
   logic        s_req, s_valid, s_mis;
   logic [31:0] s_addr, s_pc, s_instr;
   int          valid_cycles = 0;
   logic [31:0] acc_q[$];
   logic [31:0] dlv_pc_q[$];
   logic [31:0] dlv_in_q[$];

   // behavioural model: what the fetch unit is doing, in bench terms
   bit          m_fresh, m_issuing, m_inflight, m_showing, m_drop, m_mis;
   logic [31:0] m_pc, m_next, m_out_pc, m_out_instr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return fixed_instr ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
   endfunction

   function automatic logic [31:0] fix_target(input logic [31:0] t);
      return MIS_EN ? t : (t & 32'hFFFF_FFFC);
   endfunction

   function automatic logic [31:0] winner();
      if (trap_req)      return fix_target(trap_pc);
      else if (mret_req) return fix_target(mret_pc);
      else               return fix_target(branch_pc);
   endfunction

   function automatic logic [31:0] rnd_target();
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      return t;
   endfunction

   task automatic land(input logic [31:0] t);
      m_pc = t; m_drop = 0; m_issuing = 0; m_inflight = 0; m_showing = 0; m_mis = 0;
      if (MIS_EN && t[1:0] != 2'b00) begin
         m_showing = 1; m_mis = 1; m_out_pc = t; m_out_instr = '0;
      end else begin
         m_issuing = 1;
      end
   endtask

   task automatic model_step();
      bit          rd;
      logic [31:0] tg;
      rd = trap_req | mret_req | branch_req;
      tg = winner();
      if (rst) begin
         m_fresh = 1; m_issuing = 0; m_inflight = 0; m_showing = 0; m_drop = 0; m_mis = 0;
         m_pc = 32'h0; m_next = '0; m_out_pc = '0; m_out_instr = '0;
      end else if (m_fresh) begin
         m_fresh = 0;
         land(rd ? tg : m_pc);
      end else if (m_issuing) begin
         if (rd) begin m_drop = 1; m_next = tg; end
         if (ibus_ready) begin m_issuing = 0; m_inflight = 1; end
      end else if (m_inflight) begin
         if (ibus_rvalid) begin
            if (m_drop || rd) land(rd ? tg : m_next);
            else begin
               m_inflight = 0; m_showing = 1; m_mis = 0;
               m_out_pc = m_pc; m_out_instr = ibus_rdata;
            end
         end else if (rd) begin
            m_drop = 1; m_next = tg;
         end
      end else if (m_showing) begin
         if (rd) land(tg);
         else if (if_ready) land(m_pc + 32'd4);
      end
   endtask

   task automatic compare();
      chk("ibus_req", {31'b0, s_req}, {31'b0, m_issuing});
      if (m_issuing) chk("ibus_addr", s_addr, m_pc);
      chk("if_valid", {31'b0, s_valid}, {31'b0, m_showing});
      if (m_showing) begin
         chk("if_pc", s_pc, m_out_pc);
         chk("if_instr", s_instr, m_out_instr);
      end
      chk("if_misalign", {31'b0, s_mis}, {31'b0, m_showing & m_mis});
      if (m_fresh) begin
         chk("reset_if_pc", s_pc, 32'h0);
         chk("reset_if_instr", s_instr, 32'h0);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      s_req = ibus_req; s_addr = ibus_addr; s_valid = if_valid;
      s_pc = if_pc; s_instr = if_instr; s_mis = if_misalign;
      if (s_valid === 1'b1) valid_cycles++;
      compare();
      rst = rst_next;
      if (rnd_mode) begin
         trap_req   = ($urandom_range(0, 23) == 0);
         mret_req   = ($urandom_range(0, 23) == 0);
         branch_req = ($urandom_range(0, 9) == 0);
         trap_pc = rnd_target(); mret_pc = rnd_target(); branch_pc = rnd_target();
         ibus_ready = ($urandom_range(0, 2) != 0);
         if_ready   = ($urandom_range(0, 2) != 0);
      end else begin
         trap_req = d_trap; mret_req = d_mret; branch_req = d_branch;
         trap_pc = d_trap_pc; mret_pc = d_mret_pc; branch_pc = d_branch_pc;
         ibus_ready = d_ready; if_ready = d_if_ready;
      end
      ibus_rvalid = 1'b0;
      ibus_rdata  = $urandom;
      if (mem_busy && mem_cnt == 0) begin
         ibus_rvalid = 1'b1; ibus_rdata = instr_of(mem_addr);
      end else if (!mem_busy && late_rv) begin
         ibus_rvalid = 1'b1; late_rv = 1'b0;
      end else if (rnd_mode && !mem_busy && $urandom_range(0, 7) == 0) begin
         ibus_rvalid = 1'b1;
      end
      if (s_req === 1'b1 && ibus_ready) acc_q.push_back(s_addr);
      if (s_valid === 1'b1 && if_ready) begin
         dlv_pc_q.push_back(s_pc); dlv_in_q.push_back(s_instr);
      end
      @(posedge clk);
      model_step();
      if (ibus_rvalid && mem_busy && mem_cnt == 0) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (s_req === 1'b1 && ibus_ready) begin
         mem_busy = 1'b1; mem_addr = s_addr;
         mem_cnt  = rnd_mode ? int'($urandom_range(0, 2)) : mem_lat;
      end
      if (rst) begin
         if (mem_busy) late_rv = 1'b1;
         mem_busy = 1'b0;
      end
   endtask

   task automatic do_reset();
      d_trap = 0; d_mret = 0; d_branch = 0; d_ready = 0; d_if_ready = 0;
      d_trap_pc = '0; d_mret_pc = '0; d_branch_pc = '0;
      rst_next = 1'b1;
      cycle(); cycle();
      rst_next = 1'b0;
      acc_q.delete(); dlv_pc_q.delete(); dlv_in_q.delete();
      valid_cycles = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      model_step();

      // T1: back-to-back fetches, response two cycles after acceptance
      do_reset();
      d_ready = 1; d_if_ready = 1;
      for (int c = 0; c < 12; c++) cycle();
      chk("t1_acc_count", acc_q.size(), 3);
      if (acc_q.size() >= 3) begin
         chk("t1_addr0", acc_q[0], 32'h0);
         chk("t1_addr1", acc_q[1], 32'h4);
         chk("t1_addr2", acc_q[2], 32'h8);
      end
      chk("t1_dlv_count", (dlv_pc_q.size() >= 1), 1);
      if (dlv_pc_q.size() >= 1) begin
         chk("t1_dlv_pc", dlv_pc_q[0], 32'h0);
         chk("t1_dlv_instr", dlv_in_q[0], 32'h13);
      end

      // T2: decode stalls for 5 cycles in HOLD
      do_reset();
      d_ready = 1; d_if_ready = 0;
      for (int c = 0; c < 9; c++) begin
         cycle();
         if (c >= 4) begin
            chk("t2_hold_valid", {31'b0, s_valid}, 32'd1);
            chk("t2_hold_pc", s_pc, 32'h0);
            chk("t2_hold_instr", s_instr, 32'h13);
            chk("t2_hold_noreq", {31'b0, s_req}, 32'd0);
         end
      end

      // T3: branch during WAIT drops the in-flight response
      do_reset();
      d_ready = 1; d_if_ready = 1;
      for (int c = 0; c < 6; c++) begin
         d_branch = (c == 2); d_branch_pc = 32'h100;
         cycle();
      end
      d_branch = 0;
      chk("t3_acc_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) chk("t3_addr1", acc_q[1], 32'h100);
      chk("t3_no_valid", valid_cycles, 0);

      // T4: simultaneous trap/mret/branch in HOLD, trap wins over if_ready as well
      do_reset();
      d_ready = 1; d_if_ready = 0;
      for (int c = 0; c < 8; c++) begin
         d_trap = (c == 5); d_mret = (c == 5); d_branch = (c == 5); d_if_ready = (c == 5);
         d_trap_pc = 32'h200; d_mret_pc = 32'h300; d_branch_pc = 32'h400;
         cycle();
         if (c == 6) chk("t4_addr", s_addr, 32'h200);
      end
      d_trap = 0; d_mret = 0; d_branch = 0;
      chk("t4_model_pc", m_pc, 32'h200);
      chk("t4_acc_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) chk("t4_addr1", acc_q[1], 32'h200);

      // T5: redirect in REQ while the bus stalls
      do_reset();
      d_if_ready = 1;
      for (int c = 0; c < 8; c++) begin
         d_ready = (c >= 3); d_branch = (c == 1); d_branch_pc = 32'h80;
         cycle();
         if (c == 2) begin
            chk("t5_stall_req", {31'b0, s_req}, 32'd1);
            chk("t5_stall_addr", s_addr, 32'h0);
         end
      end
      d_branch = 0;
      chk("t5_acc_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) begin
         chk("t5_addr0", acc_q[0], 32'h0);
         chk("t5_addr1", acc_q[1], 32'h80);
      end
      chk("t5_no_valid", valid_cycles, 0);

      // T6: misaligned branch target from HOLD
      do_reset();
      d_ready = 1; d_if_ready = 0;
      for (int c = 0; c < 8; c++) begin
         d_branch = (c == 5); d_branch_pc = 32'h102;
         cycle();
`ifdef FETCH_MISALIGN_EXC_EN
         if (c == 6) begin
            chk("t6_mis_valid", {31'b0, s_valid}, 32'd1);
            chk("t6_mis_flag", {31'b0, s_mis}, 32'd1);
            chk("t6_mis_pc", s_pc, 32'h102);
            chk("t6_mis_noreq", {31'b0, s_req}, 32'd0);
         end
`endif
      end
      d_branch = 0;
`ifdef FETCH_MISALIGN_EXC_EN
      chk("t6_acc_count", acc_q.size(), 1);
`else
      chk("t6_acc_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) chk("t6_addr1", acc_q[1], 32'h100);
`endif

      // Randomized traffic with occasional mid-run resets
      do_reset();
      fixed_instr = 1'b0;
      rnd_mode    = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         rst_next = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rnd_mode = 1'b0;
      rst_next = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
